// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap / mret sequencer for the writeback stage.
//
// Each cycle in IDLE it looks at the writeback instruction and decides one
// of three outcomes:
//   * trap   : an interrupt or exception is present. Strobes the CSR file
//              with the cause and the faulting PC, then redirects fetch to
//              trap_vector.
//   * mret   : mret with no trap pending. Retires it, strobes the CSR file
//              and redirects fetch to mret_vector.
//   * retire : any other valid instruction simply retires.
// After a redirect the pipeline is flushed until fetch accepts the new PC.
// The flush then continues for FLUSH_CYCLES more cycles before the block
// returns to IDLE.
//
// Parameters
//   FLUSH_CYCLES   cycles of flush after the redirect handshake (1..15)
// Optional feature macro
//   TRAP_CTRL_IRQ_EN  defined: eip/tip/sip can cause traps.
//                     undefined: interrupts are ignored and interupt is 0.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   wb_valid/pc/exc/mret  writeback instruction status
//   wb_ready          writeback may complete (block is IDLE)
//   eip, tip, sip     enabled interrupt pending bits from the CSR file
//   trap_vector       handler address; mret_vector = mepc
//   traped, mret, retired  one-cycle strobes to the CSR file
//   ecp, trap_cause, interupt  mepc / mcause data for a trap
//   redirect_valid/pc/ready    fetch redirect handshake
//   flush             squash younger in-flight instructions
// ---------------------------------------------------------------------------
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_exc,
  input  logic        wb_mret,
  output logic        wb_ready,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  output logic        traped,
  output logic        mret,
  output logic        retired,
  output logic [31:0] ecp,
  output logic [3:0]  trap_cause,
  output logic        interupt,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_drain, w_drain_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;

  logic        w_irq;
  logic [3:0]  w_irq_cause;
  logic        w_exc;
  logic [3:0]  w_exc_cause;

  logic        w_traped;
  logic        w_mret;
  logic        w_retired;
  logic [31:0] w_ecp;
  logic [3:0]  w_trap_cause;
  logic        w_interupt;

  // -------------------------------------------------------------------------
  // Interrupt qualification. The CSR file already masks with mie/mstatus,
  // so any asserted bit here is a request to take the interrupt.
  // -------------------------------------------------------------------------
`ifdef TRAP_CTRL_IRQ_EN
  assign w_irq       = eip | tip | sip;
  // external > software > timer
  assign w_irq_cause = eip ? 4'd11 : (sip ? 4'd3 : 4'd7);
`else
  logic w_unused_irq;
  assign w_unused_irq = eip ^ tip ^ sip;
  assign w_irq        = 1'b0;
  assign w_irq_cause  = 4'd0;
`endif

  // -------------------------------------------------------------------------
  // Exception cause: the lowest set flag wins.
  // -------------------------------------------------------------------------
  assign w_exc = |wb_exc;

  always_comb begin
    w_exc_cause = 4'd0;
    if      (wb_exc[0]) w_exc_cause = 4'd0;   // fetch misaligned
    else if (wb_exc[1]) w_exc_cause = 4'd2;   // illegal instruction
    else if (wb_exc[2]) w_exc_cause = 4'd3;   // breakpoint
    else if (wb_exc[3]) w_exc_cause = 4'd11;  // ecall from M
    else if (wb_exc[4]) w_exc_cause = 4'd4;   // load misaligned
    else if (wb_exc[5]) w_exc_cause = 4'd6;   // store misaligned
  end

  // -------------------------------------------------------------------------
  // Next state and event strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_drain_nxt       = r_drain;
    w_redirect_pc_nxt = r_redirect_pc;
    w_traped          = 1'b0;
    w_mret            = 1'b0;
    w_retired         = 1'b0;
    w_ecp             = 32'd0;
    w_trap_cause      = 4'd0;
    w_interupt        = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Reset masks the event so no strobe leaks out of a reset cycle.
        if (wb_valid && !reset) begin
          if (w_irq || w_exc) begin
            w_traped          = 1'b1;
            w_ecp             = wb_pc;
            w_interupt        = w_irq;
            w_trap_cause      = w_irq ? w_irq_cause : w_exc_cause;
            w_redirect_pc_nxt = trap_vector;
            w_state_nxt       = S_REDIRECT;
          end else begin
            w_retired = 1'b1;
            if (wb_mret) begin
              w_mret            = 1'b1;
              w_redirect_pc_nxt = mret_vector;
              w_state_nxt       = S_REDIRECT;
            end
          end
        end
      end

      S_REDIRECT: begin
        // redirect_pc is only reloaded from IDLE, so it is stable here.
        if (redirect_ready) begin
          w_drain_nxt = FLUSH_INIT;
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // The counter holds the DRAIN cycles still to go, this one included.
        if (r_drain <= 4'd1) begin
          w_drain_nxt = 4'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_drain_nxt = r_drain - 4'd1;
        end
      end

      default: begin
        w_drain_nxt = 4'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_drain       <= 4'd0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain       <= w_drain_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wb_ready       = (r_state == S_IDLE);
  assign flush          = (r_state != S_IDLE);
  assign redirect_valid = (r_state == S_REDIRECT);
  assign redirect_pc    = r_redirect_pc;

  assign traped     = w_traped;
  assign mret       = w_mret;
  assign retired    = w_retired;
  assign ecp        = w_ecp;
  assign trap_cause = w_trap_cause;
  assign interupt   = w_interupt;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [5:0]  wb_exc;
  logic        wb_mret;
  logic        wb_ready;
  logic        eip, tip, sip;
  logic [31:0] trap_vector, mret_vector;
  logic        traped, mret, retired;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        interupt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush;

  trap_ctrl #(.FLUSH_CYCLES(FL)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_mret(wb_mret),
    .wb_ready(wb_ready),
    .eip(eip), .tip(tip), .sip(sip),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .traped(traped), .mret(mret), .retired(retired),
    .ecp(ecp), .trap_cause(trap_cause), .interupt(interupt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: "a redirect is outstanding" plus "flush cycles left".
  bit          m_redir;
  int          m_drain;
  logic [31:0] m_pc;
  bit          e_traped, e_mret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exc_cause(input logic [5:0] e);
    int tbl [6] = '{0, 2, 3, 11, 4, 6};
    for (int i = 0; i < 6; i++)
      if (e[i]) return tbl[i];
    return 0;
  endfunction

  // Wait for mid-cycle and compare every output with the model.
  task automatic check_cycle();
    bit idle, irq, exc, ev;
    int cause;
    @(negedge clk);
    idle = !m_redir && (m_drain == 0);
`ifdef TRAP_CTRL_IRQ_EN
    irq = eip | tip | sip;
`else
    irq = 1'b0;
`endif
    exc = |wb_exc;
    ev  = idle && wb_valid && !reset;
    e_traped = ev && (irq || exc);
    e_mret   = ev && wb_mret && !irq && !exc;
    if (irq) cause = eip ? 11 : (sip ? 3 : 7);
    else     cause = exc_cause(wb_exc);
    chk("wb_ready", 32'(wb_ready), 32'(idle));
    chk("flush", 32'(flush), 32'(!idle));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("traped", 32'(traped), 32'(e_traped));
    chk("mret", 32'(mret), 32'(e_mret));
    chk("retired", 32'(retired), 32'(ev && !irq && !exc));
    chk("interupt", 32'(interupt), 32'(ev && irq));
    if (e_traped) begin
      chk("ecp", ecp, wb_pc);
      chk("trap_cause", 32'(trap_cause), 32'(cause));
    end
  endtask

  // Advance the model with the same inputs, then step the clock.
  task automatic advance();
    if (reset) begin
      m_redir = 0; m_drain = 0; m_pc = 0;
    end else if (m_redir) begin
      if (redirect_ready) begin m_redir = 0; m_drain = FL; end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (e_traped) begin
      m_redir = 1; m_pc = trap_vector;
    end else if (e_mret) begin
      m_redir = 1; m_pc = mret_vector;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; wb_valid = 0; wb_pc = 0; wb_exc = 0; wb_mret = 0;
    eip = 0; tip = 0; sip = 0; redirect_ready = 0;
  endtask

  initial begin
    quiet();
    reset = 1;
    trap_vector = 32'h80;
    mret_vector = 32'h440;
    m_redir = 0; m_drain = 0; m_pc = 0;
    @(posedge clk); #1;

    // reset state (reset still asserted, wb_valid=1 must not be taken)
    wb_valid = 1;
    check_cycle();
    chk("rst_wb_ready", 32'(wb_ready), 1);
    chk("rst_retired", 32'(retired), 0);
    advance();

    // plain retire
    quiet(); wb_valid = 1; wb_pc = 32'h100;
    check_cycle();
    chk("r039_retired", 32'(retired), 1);
    chk("r039_traped", 32'(traped), 0);
    advance();
    quiet();
    check_cycle();
    chk("r039_wb_ready", 32'(wb_ready), 1);
    chk("r039_flush", 32'(flush), 0);
    advance();

    // exception trap, redirect held while fetch stalls
    wb_valid = 1; wb_exc = 6'b010010; wb_pc = 32'h200;
    check_cycle();
    chk("r040_traped", 32'(traped), 1);
    chk("r040_cause", 32'(trap_cause), 2);
    chk("r040_int", 32'(interupt), 0);
    chk("r040_ecp", ecp, 32'h200);
    chk("r040_retired", 32'(retired), 0);
    advance();
    quiet(); wb_valid = 1; wb_exc = 6'b000001;  // ignored outside IDLE
    for (int i = 0; i < 4; i++) begin
      redirect_ready = (i == 3);
      check_cycle();
      chk("r040_rv", 32'(redirect_valid), 1);
      chk("r040_rpc", redirect_pc, 32'h80);
      chk("r040_flush", 32'(flush), 1);
      advance();
    end
    redirect_ready = 0;
    for (int i = 0; i < FL; i++) begin
      check_cycle();
      chk("r040_drain_flush", 32'(flush), 1);
      chk("r040_drain_rv", 32'(redirect_valid), 0);
      advance();
    end
    quiet();
    check_cycle();
    chk("r040_idle", 32'(wb_ready), 1);
    advance();

`ifdef TRAP_CTRL_IRQ_EN
    // interrupt beats mret
    eip = 1; tip = 1; wb_mret = 1; wb_valid = 1; wb_pc = 32'h300;
    check_cycle();
    chk("r041_traped", 32'(traped), 1);
    chk("r041_int", 32'(interupt), 1);
    chk("r041_cause", 32'(trap_cause), 11);
    chk("r041_mret", 32'(mret), 0);
    chk("r041_ecp", ecp, 32'h300);
    advance();
    quiet(); redirect_ready = 1;
    check_cycle(); advance();
    redirect_ready = 0;
    for (int i = 0; i < FL; i++) begin check_cycle(); advance(); end
`else
    // interrupts ignored
    eip = 1; wb_valid = 1; wb_pc = 32'h300;
    check_cycle();
    chk("r044_retired", 32'(retired), 1);
    chk("r044_traped", 32'(traped), 0);
    advance();
`endif

    // mret
    quiet(); wb_valid = 1; wb_mret = 1;
    check_cycle();
    chk("r042_mret", 32'(mret), 1);
    chk("r042_retired", 32'(retired), 1);
    advance();
    quiet();
    check_cycle();
    chk("r042_rpc", redirect_pc, 32'h440);
    // reset in the middle of REDIRECT
    reset = 1;
    advance();
    reset = 0;
    check_cycle();
    chk("r043_rv", 32'(redirect_valid), 0);
    chk("r043_flush", 32'(flush), 0);
    chk("r043_wb_ready", 32'(wb_ready), 1);
    advance();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 49) == 0);
      wb_valid       = ($urandom_range(0, 1) == 1);
      wb_pc          = $urandom & 32'hFFFF_FFFC;
      wb_exc         = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      wb_mret        = ($urandom_range(0, 4) == 0);
      eip            = ($urandom_range(0, 9) == 0);
      tip            = ($urandom_range(0, 9) == 0);
      sip            = ($urandom_range(0, 9) == 0);
      redirect_ready = ($urandom_range(0, 2) == 0);
      trap_vector    = $urandom & 32'hFFFF_FFFC;
      mret_vector    = $urandom & 32'hFFFF_FFFC;
      check_cycle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 FLUSH_CYCLES, 2, number of cycles flush stays high after the redirect handshake (legal 1..15).
REQ-002 clk  input  1  clock, all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 wb_valid  input  1  a valid instruction sits in writeback.
REQ-005 wb_pc  input  32  PC of the writeback instruction.
REQ-006 wb_exc  input  6  exception flags: [0] fetch misaligned, [1] illegal, [2] ebreak, [3] ecall, [4] load misaligned, [5] store misaligned.
REQ-007 wb_mret  input  1  writeback instruction is mret.
REQ-008 wb_ready  output  1  writeback may complete this cycle.
REQ-009 eip  input  1  enabled external interrupt pending, from CSR file.
REQ-010 tip  input  1  enabled timer interrupt pending, from CSR file.
REQ-011 sip  input  1  enabled software interrupt pending, from CSR file.
REQ-012 trap_vector  input  32  trap handler address, from CSR file.
REQ-013 mret_vector  input  32  return address (mepc), from CSR file.
REQ-014 traped  output  1  one-cycle trap-entry strobe to CSR file.
REQ-015 mret  output  1  one-cycle mret strobe to CSR file.
REQ-016 retired  output  1  one-cycle instruction-retired strobe to CSR file.
REQ-017 ecp  output  32  PC saved into mepc on trap.
REQ-018 trap_cause  output  4  cause code for mcause.
REQ-019 interupt  output  1  trap is an interrupt (mcause[31]).
REQ-020 redirect_valid  output  1  fetch redirect request.
REQ-021 redirect_pc  output  32  fetch redirect target.
REQ-022 redirect_ready  input  1  fetch accepts the redirect.
REQ-023 flush  output  1  squash all younger in-flight instructions.

Function
REQ-024 States: IDLE, REDIRECT, DRAIN; wb_ready = (state==IDLE), flush = (state!=IDLE), redirect_valid = (state==REDIRECT).
REQ-025 Event = IDLE && wb_valid; irq = eip|tip|sip; exc = |wb_exc.
REQ-026 traped, mret, retired, ecp, trap_cause and interupt are combinational in the event cycle and 0 in all other cycles; ecp and trap_cause are don't-care when traped=0.
REQ-027 Trap taken when event && (irq || exc): traped=1, ecp=wb_pc, retired=0, mret=0.
REQ-028 Interrupt beats exception; interrupt priority eip(cause 11) > sip(3) > tip(7), interupt=1.
REQ-029 Exception priority is lowest wb_exc bit first; causes by bit 0..5 are 0, 2, 3, 11, 4, 6; interupt=0.
REQ-030 mret taken when event && wb_mret && !irq && !exc: mret=1, retired=1.
REQ-031 Plain retire when event && !irq && !exc && !wb_mret: retired=1, state stays IDLE.
REQ-032 On trap: redirect_pc <= trap_vector; on mret: redirect_pc <= mret_vector; state <= REDIRECT.
REQ-033 REDIRECT: redirect_valid and redirect_pc are held stable until redirect_ready=1; a handshake in the first REDIRECT cycle is legal.
REQ-034 On handshake: drain counter <= FLUSH_CYCLES, state <= DRAIN; DRAIN lasts exactly FLUSH_CYCLES cycles, then IDLE.
REQ-035 wb_valid, wb_exc and irq are ignored outside IDLE; a pending irq is re-evaluated on the first IDLE cycle.

Reset
REQ-036 reset forces state IDLE, drain counter 0, redirect_pc 0, flush 0, redirect_valid 0, wb_ready 1, and all strobes 0; reset takes priority in any state, including mid-REDIRECT and mid-DRAIN.
REQ-037 No event is taken in a cycle with reset=1.

Configuration
REQ-038 TRAP_CTRL_IRQ_EN defined: interrupt handling per REQ-027/028. Undefined: eip/tip/sip ignored (irq=0), interupt tied 0, only exceptions trap.

Verification
REQ-039 wb_valid=1, wb_exc=0, wb_pc=0x100 -> retired=1, traped=0; next cycle wb_ready=1, flush=0.
REQ-040 trap_vector=0x80, wb_exc=6'b010010, wb_pc=0x200 -> traped=1, trap_cause=2, interupt=0, ecp=0x200, retired=0; next cycle redirect_valid=1, redirect_pc=0x80, flush=1; redirect_ready low 3 cycles then high -> redirect held 4 cycles, flush high 2 more cycles, then wb_ready=1.
REQ-041 (IRQ_EN) eip=1, tip=1, wb_mret=1, wb_pc=0x300 -> traped=1, interupt=1, trap_cause=11, mret=0, ecp=0x300.
REQ-042 wb_mret=1, mret_vector=0x440, no irq/exc -> mret=1, retired=1; next cycle redirect_pc=0x440.
REQ-043 reset=1 during REDIRECT -> next cycle redirect_valid=0, flush=0, wb_ready=1.
REQ-044 (no IRQ_EN) eip=1, wb_valid=1, wb_exc=0 -> retired=1, traped=0.
